// File: rtl/dense_output_layer.sv
// dense_output_layer
//
// Sequential fully-connected output layer. On a start request it latches the
// input vector, then computes NEURON_NB signed dot products against an
// internal weight/bias memory, one multiply-accumulate per clock. Each result
// plus its bias is saturated to 2*WIDTH bits and registered into out_data.
// layer_done rises with the last neuron's write and holds until reset.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high
//   enable      in   start request, sampled only while idle
//   in_data     in   INPUT_NB signed WIDTH-bit inputs, latched on start
//   w_wr_en     in   weight-memory write strobe (honoured only idle/done)
//   w_wr_addr   in   word address n*(INPUT_NB+1)+k; k==INPUT_NB is the bias
//   w_wr_data   in   signed WIDTH-bit weight or bias word
//   out_data    out  NEURON_NB signed 2*WIDTH-bit saturated outputs
//   layer_done  out  level, high once every out_data entry is final

module dense_output_layer #(
  parameter int INPUT_NB  = 16,
  parameter int NEURON_NB = 10,
  parameter int WIDTH     = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic [0:INPUT_NB-1][WIDTH-1:0]                in_data,
  input  logic                                          w_wr_en,
  input  logic [$clog2(NEURON_NB*(INPUT_NB+1))-1:0]     w_wr_addr,
  input  logic [WIDTH-1:0]                              w_wr_data,
  output logic [0:NEURON_NB-1][2*WIDTH-1:0]             out_data,
  output logic                                          layer_done
);

  localparam int MemDepth = NEURON_NB * (INPUT_NB + 1);
  localparam int AddrW    = $clog2(MemDepth);
  localparam int OutW     = 2 * WIDTH;
  // Wide enough that INPUT_NB full-scale products can never overflow.
  localparam int AccW     = OutW + $clog2(INPUT_NB) + 1;
  // One extra bit so adding the bias cannot overflow either.
  localparam int SumW     = AccW + 1;
  localparam int KW       = (INPUT_NB > 1) ? $clog2(INPUT_NB) : 1;
  localparam int NW       = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;

  localparam logic signed [SumW-1:0] SatMax = SumW'((1 << (OutW - 1)) - 1);
  localparam logic signed [SumW-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StStore,
    StDone
  } state_t;

  // Weight/bias storage; deliberately not touched by reset.
  logic [WIDTH-1:0]                     r_mem [MemDepth];

  state_t                               r_state;
  logic [0:INPUT_NB-1][WIDTH-1:0]       r_in;
  logic signed [AccW-1:0]               r_acc;
  logic [KW-1:0]                        r_k;
  logic [NW-1:0]                        r_n;
  // Address of w[r_n][0], stepped by INPUT_NB+1 per neuron to avoid a multiplier.
  logic [AddrW-1:0]                     r_base;
  logic [0:NEURON_NB-1][OutW-1:0]       r_out;
  logic                                 r_done;

  logic                                 w_wr_ok;
  logic [AddrW-1:0]                     w_rd_addr;
  logic [WIDTH-1:0]                     w_rd_data;
  logic [WIDTH-1:0]                     w_x;
  logic signed [OutW-1:0]               w_prod;
  logic signed [AccW-1:0]               w_prod_ext;
  logic signed [SumW-1:0]               w_sum;
  logic [OutW-1:0]                      w_sat;

  assign out_data   = r_out;
  assign layer_done = r_done;

  // Writes are blocked while a run is reading the memory, and out-of-range
  // addresses are dropped.
  always_comb begin
    w_wr_ok = w_wr_en
              && ((r_state == StIdle) || (r_state == StDone))
              && (int'(w_wr_addr) < MemDepth);
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Combinational read: weight k while accumulating, bias during STORE.
  always_comb begin
    if (r_state == StStore) begin
      w_rd_addr = r_base + AddrW'(INPUT_NB);
    end else begin
      w_rd_addr = r_base + AddrW'(r_k);
    end
    w_rd_data = r_mem[w_rd_addr];
  end

  // Full-precision signed product of the current input and weight.
  always_comb begin
    w_x        = r_in[r_k];
    w_prod     = $signed({{WIDTH{w_x[WIDTH-1]}}, w_x})
               * $signed({{WIDTH{w_rd_data[WIDTH-1]}}, w_rd_data});
    w_prod_ext = $signed({{(AccW - OutW){w_prod[OutW-1]}}, w_prod});
  end

  // Bias add and clamp to the 2*WIDTH signed range.
  always_comb begin
    w_sum = $signed({r_acc[AccW-1], r_acc})
          + $signed({{(SumW - WIDTH){w_rd_data[WIDTH-1]}}, w_rd_data});
    if (w_sum > SatMax) begin
      w_sat = {1'b0, {(OutW - 1){1'b1}}};
    end else if (w_sum < SatMin) begin
      w_sat = {1'b1, {(OutW - 1){1'b0}}};
    end else begin
      w_sat = w_sum[OutW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_in    <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_base  <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (enable) begin
            r_in    <= in_data;
            r_acc   <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_base  <= '0;
            r_state <= StMac;
          end
        end
        StMac: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_k == KW'(INPUT_NB - 1)) begin
            r_state <= StStore;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        StStore: begin
          r_out[r_n] <= w_sat;
          r_acc      <= '0;
          r_k        <= '0;
          if (r_n == NW'(NEURON_NB - 1)) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_n     <= r_n + NW'(1);
            r_base  <= r_base + AddrW'(INPUT_NB + 1);
            r_state <= StMac;
          end
        end
        StDone: begin
          // Terminal until reset; enable is ignored here.
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
